// File: rtl/freq_div_prog.sv
// Programmable clock divider: N-cycle output period, HI = N>>1 high cycles, glitch-free divisor reload at wrap.
// Optional tick counter output enabled by defining FREQ_DIV_PROG_TICK_CNT_EN.
`timescale 1ns/1ps
module freq_div_prog #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DIV_INIT = 100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] div_value,
   input  logic             div_load,
   output logic             clk_div,
   output logic             tick,
   output logic             pending,
   output logic             div_err
`ifdef FREQ_DIV_PROG_TICK_CNT_EN
   ,
   output logic [15:0]      tick_cnt
`endif
);

   localparam logic [WIDTH-1:0] INIT_N = WIDTH'(DIV_INIT);
   localparam logic [WIDTH-1:0] MIN_N  = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   logic [WIDTH-1:0] n_q, cnt_q, shadow_q;
   logic [WIDTH-1:0] load_val, last_cur, n_nxt, cnt_nxt, shadow_nxt, hi_nxt, last_nxt;
   logic             wrap, pending_nxt, clk_div_nxt, tick_nxt, err_nxt;

   // Next-state: divisor takes effect only at a wrap or while idle, so no period is ever truncated.
   always_comb begin
      n_nxt       = n_q;
      cnt_nxt     = cnt_q;
      shadow_nxt  = shadow_q;
      pending_nxt = pending;
      clk_div_nxt = 1'b0;
      tick_nxt    = 1'b0;
      load_val    = (div_value < MIN_N) ? MIN_N : div_value;
      err_nxt     = div_err | (div_load & (div_value < MIN_N));
      last_cur    = n_q - ONE;
      wrap        = (cnt_q >= last_cur);

      if (!en || wrap) begin
         if (div_load) begin
            n_nxt      = load_val;
            shadow_nxt = load_val;
         end else if (pending) begin
            n_nxt = shadow_q;
         end
         pending_nxt = 1'b0;
      end else if (div_load) begin
         shadow_nxt  = load_val;
         pending_nxt = 1'b1;
      end

      last_nxt = n_nxt - ONE;
      hi_nxt   = n_nxt >> 1;

      if (!en) begin
         cnt_nxt = last_nxt;
      end else begin
         cnt_nxt     = wrap ? '0 : (cnt_q + ONE);
         clk_div_nxt = (cnt_nxt < hi_nxt);
         tick_nxt    = (cnt_nxt == last_nxt);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_q      <= INIT_N;
         cnt_q    <= INIT_N - ONE;
         shadow_q <= INIT_N;
         pending  <= 1'b0;
         clk_div  <= 1'b0;
         tick     <= 1'b0;
         div_err  <= 1'b0;
      end else begin
         n_q      <= n_nxt;
         cnt_q    <= cnt_nxt;
         shadow_q <= shadow_nxt;
         pending  <= pending_nxt;
         clk_div  <= clk_div_nxt;
         tick     <= tick_nxt;
         div_err  <= err_nxt;
      end
   end

`ifdef FREQ_DIV_PROG_TICK_CNT_EN
   // Counts completed output periods, free-running wrap at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= 16'd0;
      end else if (tick) begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_freq_div_prog.sv
// Scoreboard bench for freq_div_prog: stimulus queues expected {period length, high cycles}; monitor checks each tick.
`timescale 1ns/1ps
module tb_freq_div_prog;

   logic       clk;
   logic       reset;
   logic       en;
   logic [7:0] div_value;
   logic       div_load;
   logic       clk_div;
   logic       tick;
   logic       pending;
   logic       div_err;
`ifdef FREQ_DIV_PROG_TICK_CNT_EN
   logic [15:0] tick_cnt;
`endif

   typedef struct {
      int len;
      int hi;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   failures;

   freq_div_prog #(.WIDTH(8), .DIV_INIT(100)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .div_value (div_value),
      .div_load  (div_load),
      .clk_div   (clk_div),
      .tick      (tick),
      .pending   (pending),
      .div_err   (div_err)
`ifdef FREQ_DIV_PROG_TICK_CNT_EN
      ,
      .tick_cnt  (tick_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #1 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int len, input int hi, input int reps);
      exp_t x;
      x.len = len;
      x.hi  = hi;
      for (int i = 0; i < reps; i++) sb.push_back(x);
   endtask

   task automatic wait_tick();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!tick && k < 300);
      checks++;
      if (!tick) begin
         failures++;
         $display("FAIL tick_timeout actual=no_tick required=tick within 300 cycles at %0t", $time);
      end
   endtask

   task automatic load_now(input logic [7:0] v);
      div_value = v;
      div_load  = 1'b1;
      @(negedge clk);
      div_load  = 1'b0;
   endtask

   // Monitor: accumulate one output period per tick, compare against scoreboard head.
   initial begin
      int   len;
      int   hi;
      logic e;
      exp_t x;
      len = 0;
      hi  = 0;
      forever begin
         @(posedge clk);
         e = en && reset;
         @(negedge clk);
         if (!e || !reset) begin
            len = 0;
            hi  = 0;
         end else begin
            len++;
            if (clk_div) hi++;
            if (tick) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_unexpected_tick actual=len%0d required=none at %0t", len, $time);
               end else begin
                  x = sb.pop_front();
                  chk("period_len", len, x.len);
                  chk("period_high", hi, x.hi);
               end
               len = 0;
               hi  = 0;
            end
         end
      end
   end

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b0;
      en        = 1'b1;
      div_load  = 1'b0;
      div_value = 8'd0;

      // Reset then default 100-cycle, 50/50 operation
      push(100, 50, 2);
      repeat (5) @(negedge clk);
      chk("rst_clk_div", int'(clk_div), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_div_err", int'(div_err), 0);
`ifdef FREQ_DIV_PROG_TICK_CNT_EN
      chk("rst_tick_cnt", int'(tick_cnt), 0);
`endif
      reset = 1'b1;
      @(negedge clk);
      chk("first_rise", int'(clk_div), 1);
      wait_tick();
      wait_tick();

      // Load 5 at cnt=30: pending until wrap, then 2/3 periods
      push(100, 50, 1);
      push(5, 2, 4);
      repeat (31) @(negedge clk);
      load_now(8'd5);
      chk("pending_set", int'(pending), 1);
      wait_tick();
      chk("pending_at_tick", int'(pending), 1);
      @(negedge clk);
      chk("pending_clr", int'(pending), 0);
      repeat (4) wait_tick();

      // Last load wins; load exactly on wrap applies directly
      push(5, 2, 1);
      push(9, 4, 1);
      push(6, 3, 2);
      @(negedge clk);
      div_value = 8'd7;
      div_load  = 1'b1;
      @(negedge clk);
      div_value = 8'd9;
      @(negedge clk);
      div_load  = 1'b0;
      chk("pending_79", int'(pending), 1);
      wait_tick();
      wait_tick();
      load_now(8'd6);
      chk("wrap_load_no_pending", int'(pending), 0);
      wait_tick();
      wait_tick();

      // Illegal divisor 0 clamps to 2 and sets sticky error
      push(2, 1, 3);
      load_now(8'd0);
      chk("div_err_set", int'(div_err), 1);
      chk("zero_no_pending", int'(pending), 0);
      repeat (3) wait_tick();
      push(10, 5, 1);
      load_now(8'd10);
      wait_tick();
      chk("div_err_sticky", int'(div_err), 1);

      // Back to 100, drop en at cnt=40 for 20 cycles
      load_now(8'd100);
      repeat (40) @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_clk_div", int'(clk_div), 0);
         chk("idle_tick", int'(tick), 0);
      end
      push(100, 50, 1);
      en = 1'b1;
      wait_tick();

      // Async reset mid-high-phase with a load pending
      repeat (10) @(negedge clk);
      load_now(8'd5);
      chk("pre_rst_pending", int'(pending), 1);
      chk("pre_rst_high", int'(clk_div), 1);
      #0.5;
      reset = 1'b0;
      #0.1;
      chk("async_clk_div", int'(clk_div), 0);
      chk("async_tick", int'(tick), 0);
      repeat (3) @(negedge clk);
      chk("rst2_pending", int'(pending), 0);
      chk("rst2_div_err", int'(div_err), 0);
`ifdef FREQ_DIV_PROG_TICK_CNT_EN
      chk("rst2_tick_cnt", int'(tick_cnt), 0);
`endif
      push(100, 50, 1);
      reset = 1'b1;
      wait_tick();

      @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
